// File: rtl/pulse_sweep_sequencer_if.sv
// Configuration bus and active-parameter outputs of the pulse sweep sequencer.
// A write transfers on any clock edge where wr_valid && wr_ready; the master holds addr/data stable while valid.
interface pulse_sweep_sequencer_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        commit;
    logic        frame_tick;
    logic [7:0]  per;
    logic [15:0] p1wid;
    logic [15:0] p2wid;
    logic [15:0] del;
    logic [31:0] nut_w;
    logic [31:0] nut_d;
    logic [7:0]  cp;
    logic [7:0]  p_bl;
    logic [15:0] p_bl_off;
    logic        bl;
    logic        pu;
    logic [15:0] point_idx;
    logic [15:0] shot_idx;
    logic        point_tick;
    logic        sweep_done;
    logic        busy;
    logic        del_sat;

    modport master (
        output wr_valid, wr_addr, wr_data, commit, frame_tick,
        input  wr_ready, per, p1wid, p2wid, del, nut_w, nut_d, cp, p_bl, p_bl_off,
               bl, pu, point_idx, shot_idx, point_tick, sweep_done, busy, del_sat
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, commit, frame_tick,
        output wr_ready, per, p1wid, p2wid, del, nut_w, nut_d, cp, p_bl, p_bl_off,
               bl, pu, point_idx, shot_idx, point_tick, sweep_done, busy, del_sat
    );
endinterface

// File: rtl/pulse_sweep_sequencer.sv
// Staged/active parameter sets for the pulses generator, applied atomically on a period
// boundary, with an optional delay sweep that holds each point for a fixed number of shots.
module pulse_sweep_sequencer #(
    parameter int DEF_DEL = 200,
    parameter int DEF_PW  = 30
) (
    input  logic                           clk_pll,
    input  logic                           reset,
    pulse_sweep_sequencer_if.slave         bus,
    output logic [1:0]                     o_dbg_state
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SWEEP   = 2'd2
    } state_t;

    localparam logic [15:0] RST_DEL = 16'(DEF_DEL);
    localparam logic [15:0] RST_PW  = 16'(DEF_PW);

    state_t r_state;
    state_t w_state_nxt;

    // Staged set (write target)
    logic [7:0]  r_s_per;
    logic [15:0] r_s_p1wid, r_s_p2wid, r_s_del_start, r_s_del_step, r_s_p_bl_off;
    logic [15:0] r_s_n_points, r_s_n_shots;
    logic [31:0] r_s_nut_w, r_s_nut_d;
    logic [7:0]  r_s_cp, r_s_p_bl;
    logic        r_s_pu, r_s_bl, r_s_sweep_en, r_s_loop;

    // Active set
    logic [7:0]  r_per;
    logic [15:0] r_p1wid, r_p2wid, r_del, r_del_start, r_del_step, r_p_bl_off;
    logic [15:0] r_n_points, r_n_shots, r_point_idx, r_shot_idx;
    logic [31:0] r_nut_w, r_nut_d;
    logic [7:0]  r_cp, r_p_bl;
    logic        r_pu, r_bl, r_loop;
    logic        r_point_tick, r_sweep_done, r_busy, r_del_sat, r_wr_ready;

    logic               w_wr_fire, w_apply, w_step, w_sweep_ok;
    logic               w_shot_more, w_point_more, w_del_lo, w_del_hi;
    logic signed [17:0] w_del_sum;
    logic [15:0]        w_del_next;

    assign w_wr_fire    = bus.wr_valid && r_wr_ready;
    assign w_sweep_ok   = r_s_sweep_en && (r_s_n_points != 16'd0) && (r_s_n_shots != 16'd0);
    assign w_apply      = (r_state == ST_PENDING) && bus.frame_tick;
    assign w_step       = (r_state == ST_SWEEP) && bus.frame_tick;
    assign w_shot_more  = ({1'b0, r_shot_idx} + 17'd1) < {1'b0, r_n_shots};
    assign w_point_more = ({1'b0, r_point_idx} + 17'd1) < {1'b0, r_n_points};

    // Delay step in 18-bit signed space, clamped into the unsigned 16-bit range.
    assign w_del_sum  = $signed({2'b00, r_del}) + $signed({{2{r_del_step[15]}}, r_del_step});
    assign w_del_lo   = w_del_sum < 18'sd0;
    assign w_del_hi   = w_del_sum > 18'sd65535;
    assign w_del_next = w_del_lo ? 16'd0 : (w_del_hi ? 16'hFFFF : w_del_sum[15:0]);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.commit) w_state_nxt = ST_PENDING;
            end
            ST_PENDING: begin
                if (bus.frame_tick) w_state_nxt = w_sweep_ok ? ST_SWEEP : ST_IDLE;
            end
            ST_SWEEP: begin
                if (bus.commit)
                    w_state_nxt = ST_PENDING;
                else if (bus.frame_tick && !w_shot_more && !w_point_more && !r_loop)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_pll) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_pll) begin
        if (!reset) begin
            r_s_per       <= 8'd1;
            r_s_p1wid     <= RST_PW;
            r_s_p2wid     <= RST_PW;
            r_s_del_start <= RST_DEL;
            r_s_del_step  <= 16'd0;
            r_s_nut_w     <= 32'd50;
            r_s_nut_d     <= 32'd300;
            r_s_cp        <= 8'd3;
            r_s_p_bl      <= 8'd50;
            r_s_p_bl_off  <= 16'd100;
            r_s_pu        <= 1'b1;
            r_s_bl        <= 1'b1;
            r_s_n_points  <= 16'd0;
            r_s_n_shots   <= 16'd0;
            r_s_sweep_en  <= 1'b0;
            r_s_loop      <= 1'b0;
        end else if (w_wr_fire) begin
            case (bus.wr_addr)
                4'd0:  r_s_per       <= bus.wr_data[7:0];
                4'd1:  r_s_p1wid     <= bus.wr_data[15:0];
                4'd2:  r_s_p2wid     <= bus.wr_data[15:0];
                4'd3:  r_s_del_start <= bus.wr_data[15:0];
                4'd4:  r_s_del_step  <= bus.wr_data[15:0];
                4'd5:  r_s_nut_w     <= bus.wr_data;
                4'd6:  r_s_nut_d     <= bus.wr_data;
                4'd7:  r_s_cp        <= bus.wr_data[7:0];
                4'd8:  r_s_p_bl      <= bus.wr_data[7:0];
                4'd9:  r_s_p_bl_off  <= bus.wr_data[15:0];
                4'd10: {r_s_bl, r_s_pu} <= bus.wr_data[1:0];
                4'd11: r_s_n_points  <= bus.wr_data[15:0];
                4'd12: r_s_n_shots   <= bus.wr_data[15:0];
                4'd13: {r_s_loop, r_s_sweep_en} <= bus.wr_data[1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_pll) begin
        if (!reset) begin
            r_per        <= 8'd1;
            r_p1wid      <= RST_PW;
            r_p2wid      <= RST_PW;
            r_del        <= RST_DEL;
            r_del_start  <= RST_DEL;
            r_del_step   <= 16'd0;
            r_nut_w      <= 32'd50;
            r_nut_d      <= 32'd300;
            r_cp         <= 8'd3;
            r_p_bl       <= 8'd50;
            r_p_bl_off   <= 16'd100;
            r_pu         <= 1'b1;
            r_bl         <= 1'b1;
            r_n_points   <= 16'd0;
            r_n_shots    <= 16'd0;
            r_loop       <= 1'b0;
            r_point_idx  <= 16'd0;
            r_shot_idx   <= 16'd0;
            r_point_tick <= 1'b0;
            r_sweep_done <= 1'b0;
            r_del_sat    <= 1'b0;
            r_busy       <= 1'b0;
            r_wr_ready   <= 1'b1;
        end else begin
            r_point_tick <= 1'b0;
            r_sweep_done <= 1'b0;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_wr_ready   <= (w_state_nxt != ST_PENDING);
            if (w_apply) begin
                r_per       <= r_s_per;
                r_p1wid     <= r_s_p1wid;
                r_p2wid     <= r_s_p2wid;
                r_del       <= r_s_del_start;
                r_del_start <= r_s_del_start;
                r_del_step  <= r_s_del_step;
                r_nut_w     <= r_s_nut_w;
                r_nut_d     <= r_s_nut_d;
                r_cp        <= r_s_cp;
                r_p_bl      <= r_s_p_bl;
                r_p_bl_off  <= r_s_p_bl_off;
                r_pu        <= r_s_pu;
                r_bl        <= r_s_bl;
                r_n_points  <= r_s_n_points;
                r_n_shots   <= r_s_n_shots;
                r_loop      <= r_s_loop;
                r_point_idx <= 16'd0;
                r_shot_idx  <= 16'd0;
                r_del_sat   <= 1'b0;
            end else if (w_step) begin
                if (w_shot_more) begin
                    r_shot_idx <= r_shot_idx + 16'd1;
                end else if (w_point_more) begin
                    r_shot_idx   <= 16'd0;
                    r_point_idx  <= r_point_idx + 16'd1;
                    r_del        <= w_del_next;
                    r_del_sat    <= r_del_sat | w_del_lo | w_del_hi;
                    r_point_tick <= 1'b1;
                end else begin
                    // Without loop the indices and delay stay on the final point.
                    r_sweep_done <= 1'b1;
                    if (r_loop) begin
                        r_point_idx <= 16'd0;
                        r_shot_idx  <= 16'd0;
                        r_del       <= r_del_start;
                    end
                end
            end
        end
    end

    assign bus.wr_ready   = r_wr_ready;
    assign bus.per        = r_per;
    assign bus.p1wid      = r_p1wid;
    assign bus.p2wid      = r_p2wid;
    assign bus.del        = r_del;
    assign bus.nut_w      = r_nut_w;
    assign bus.nut_d      = r_nut_d;
    assign bus.cp         = r_cp;
    assign bus.p_bl       = r_p_bl;
    assign bus.p_bl_off   = r_p_bl_off;
    assign bus.bl         = r_bl;
    assign bus.pu         = r_pu;
    assign bus.point_idx  = r_point_idx;
    assign bus.shot_idx   = r_shot_idx;
    assign bus.point_tick = r_point_tick;
    assign bus.sweep_done = r_sweep_done;
    assign bus.busy       = r_busy;
    assign bus.del_sat    = r_del_sat;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_pulse_sweep_sequencer.sv
// Bench for pulse_sweep_sequencer: directed scenarios plus randomized sweeps checked
// against a frame-list model of staged/active parameters and sweep progression.
module tb_pulse_sweep_sequencer;
  logic       clk_pll = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int tests_run = 0;
  int tests_failed = 0;

  pulse_sweep_sequencer_if bus();

  pulse_sweep_sequencer #(.DEF_DEL(200), .DEF_PW(30)) dut (
    .clk_pll     (clk_pll),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk_pll = ~clk_pll;

  // Register-file model: st is what has been written, act is what was last applied.
  logic [31:0] st[16];
  logic [31:0] act[16];

  function automatic logic [137:0] exp_cfg();
    return {act[0][7:0], act[1][15:0], act[2][15:0], act[5], act[6], act[7][7:0],
            act[8][7:0], act[9][15:0], act[10][1], act[10][0]};
  endfunction

  function automatic logic [137:0] dut_cfg();
    return {bus.per, bus.p1wid, bus.p2wid, bus.nut_w, bus.nut_d, bus.cp,
            bus.p_bl, bus.p_bl_off, bus.bl, bus.pu};
  endfunction

  function automatic logic [51:0] pack(bit pt, bit sd, bit bz, bit sat, logic [15:0] d,
                                       logic [15:0] p, logic [15:0] s);
    return {pt, sd, bz, sat, d, p, s};
  endfunction

  function automatic logic [51:0] dut_frame();
    return {bus.point_tick, bus.sweep_done, bus.busy, bus.del_sat, bus.del, bus.point_idx, bus.shot_idx};
  endfunction

  task automatic step();
    @(posedge clk_pll);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) st[i] = 32'd0;
    st[0] = 1; st[1] = 30; st[2] = 30; st[3] = 200; st[4] = 0;
    st[5] = 50; st[6] = 300; st[7] = 3; st[8] = 50; st[9] = 100; st[10] = 3;
    act = st;
  endtask

  task automatic do_reset();
    bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.commit = 0; bus.frame_tick = 0;
    reset = 0;
    step();
    step();
    reset = 1;
    model_reset();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.wr_valid = 1; bus.wr_addr = a; bus.wr_data = d;
    step();
    bus.wr_valid = 0;
    st[a] = d;
  endtask

  task automatic do_commit();
    bus.commit = 1;
    step();
    bus.commit = 0;
  endtask

  task automatic tick();
    bus.frame_tick = 1;
    step();
    bus.frame_tick = 0;
  endtask

  // Programs a sweep, commits it, and checks n_ticks frames against an enumerated frame list.
  task automatic run_sweep(input logic [15:0] start, input logic [15:0] stp, input int np,
                           input int ns, input bit en, input bit lp, input int n_ticks,
                           input string name);
    logic [51:0] exp_q[$];
    logic [51:0] got, exp;
    int f, d, p, s;
    bit sat, running, pt, sd;
    wr(4'd3, {16'd0, start});
    wr(4'd4, {16'd0, stp});
    wr(4'd11, np);
    wr(4'd12, ns);
    wr(4'd13, {30'd0, lp, en});
    do_commit();
    tests_run++;
    if ({bus.busy, bus.wr_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL %s pending busy/wr_ready: got %b expected 10", name, {bus.busy, bus.wr_ready});
    end
    step();
    step();
    running = en && np != 0 && ns != 0;
    d = int'(start); sat = 0; f = 0;
    exp_q.push_back(pack(0, 0, running, 0, start, 0, 0));
    for (int k = 1; k < n_ticks; k++) begin
      pt = 0; sd = 0;
      if (running) begin
        if (f + 1 == np * ns) begin
          sd = 1;
          if (lp) begin f = 0; d = int'(start); end
          else running = 0;
        end else begin
          if ((f + 1) / ns != f / ns) begin
            d = d + int'($signed(stp));
            if (d < 0) begin d = 0; sat = 1; end
            else if (d > 65535) begin d = 65535; sat = 1; end
            pt = 1;
          end
          f = f + 1;
        end
      end
      p = (ns == 0) ? 0 : f / ns;
      s = (ns == 0) ? 0 : f % ns;
      exp_q.push_back(pack(pt, sd, running, sat, d[15:0], p[15:0], s[15:0]));
    end
    act = st;
    for (int k = 0; k < n_ticks; k++) begin
      tick();
      if (k == 0) begin
        tests_run++;
        if (dut_cfg() !== exp_cfg()) begin
          tests_failed++;
          $display("FAIL %s apply cfg: got %h expected %h", name, dut_cfg(), exp_cfg());
        end
      end
      got = dut_frame();
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL %s frame %0d {pt,sd,busy,sat,del,pt_idx,shot}: got %h expected %h", name, k, got, exp);
      end
      step();
      tests_run++;
      if ({bus.point_tick, bus.sweep_done} !== 2'b00) begin
        tests_failed++;
        $display("FAIL %s pulse width frame %0d: got %b expected 00", name, k, {bus.point_tick, bus.sweep_done});
      end
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (dut_cfg() !== exp_cfg() || dut_frame() !== pack(0, 0, 0, 0, 16'd200, 0, 0) || bus.wr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset values: cfg %h frame %h ready %b expected cfg %h frame %h ready 1",
               dut_cfg(), dut_frame(), bus.wr_ready, exp_cfg(), pack(0, 0, 0, 0, 16'd200, 0, 0));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (dut_cfg() !== exp_cfg() || bus.del !== 16'd200 || bus.cp !== 8'd3 || bus.busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset hold tick %0d: cfg %h del %0d busy %b expected cfg %h del 200 busy 0",
                 i, dut_cfg(), bus.del, bus.busy, exp_cfg());
      end
    end
  endtask

  task automatic test_commit_apply();
    do_reset();
    wr(4'd1, 32'd40);
    wr(4'd3, 32'd500);
    do_commit();
    tests_run++;
    if ({bus.busy, bus.wr_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL commit pending busy/wr_ready: got %b expected 10", {bus.busy, bus.wr_ready});
    end
    for (int i = 0; i < 19; i++) begin
      step();
      tests_run++;
      if (dut_cfg() !== exp_cfg() || bus.del !== 16'd200 || bus.wr_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL commit before tick cycle %0d: cfg %h del %0d ready %b expected cfg %h del 200 ready 0",
                 i, dut_cfg(), bus.del, bus.wr_ready, exp_cfg());
      end
    end
    tick();
    act = st;
    tests_run++;
    if (dut_cfg() !== exp_cfg() || bus.p1wid !== 16'd40 || bus.del !== 16'd500 ||
        bus.busy !== 1'b0 || bus.wr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL commit apply: p1wid %0d del %0d busy %b ready %b expected p1wid 40 del 500 busy 0 ready 1",
               bus.p1wid, bus.del, bus.busy, bus.wr_ready);
    end
  endtask

  task automatic test_sweep();
    do_reset();
    run_sweep(16'd200, 16'd100, 3, 2, 1'b1, 1'b0, 8, "sweep");
    tests_run++;
    if (bus.del !== 16'd400 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL sweep end: del %0d busy %b expected del 400 busy 0", bus.del, bus.busy);
    end
  endtask

  task automatic test_sweep_loop();
    do_reset();
    run_sweep(16'd200, 16'd100, 3, 2, 1'b1, 1'b1, 10, "loop");
    tests_run++;
    if (bus.busy !== 1'b1 || bus.del !== 16'd300) begin
      tests_failed++;
      $display("FAIL loop continues: busy %b del %0d expected busy 1 del 300", bus.busy, bus.del);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    run_sweep(16'd100, 16'hFF6A, 2, 1, 1'b1, 1'b0, 4, "sat_lo");
    tests_run++;
    if (bus.del !== 16'd0 || bus.del_sat !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat low: del %0d sat %b expected del 0 sat 1", bus.del, bus.del_sat);
    end
    wr(4'd13, 32'd0);
    do_commit();
    step();
    tick();
    tests_run++;
    if (bus.del_sat !== 1'b0 || bus.del !== 16'd100 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat clear on apply: sat %b del %0d busy %b expected sat 0 del 100 busy 0",
               bus.del_sat, bus.del, bus.busy);
    end
    do_reset();
    run_sweep(16'd65000, 16'd1000, 2, 1, 1'b1, 1'b0, 3, "sat_hi");
  endtask

  task automatic test_commit_in_sweep();
    do_reset();
    run_sweep(16'd200, 16'd100, 3, 2, 1'b1, 1'b0, 2, "cis");
    tests_run++;
    if (bus.wr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL sweep wr_ready: got %b expected 1", bus.wr_ready);
    end
    wr(4'd1, 32'd77);
    wr(4'd3, 32'd1000);
    wr(4'd13, 32'd0);
    bus.commit = 1; bus.frame_tick = 1;
    step();
    bus.commit = 0; bus.frame_tick = 0;
    tests_run++;
    if (dut_frame() !== pack(1, 0, 1, 0, 16'd300, 16'd1, 16'd0) || bus.wr_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL commit+tick in sweep: frame %h ready %b expected frame %h ready 0",
               dut_frame(), bus.wr_ready, pack(1, 0, 1, 0, 16'd300, 16'd1, 16'd0));
    end
    repeat (3) step();
    tick();
    act = st;
    tests_run++;
    if (dut_cfg() !== exp_cfg() || dut_frame() !== pack(0, 0, 0, 0, 16'd1000, 0, 0)) begin
      tests_failed++;
      $display("FAIL new set after abandon: cfg %h frame %h expected cfg %h frame %h",
               dut_cfg(), dut_frame(), exp_cfg(), pack(0, 0, 0, 0, 16'd1000, 0, 0));
    end
  endtask

  task automatic test_idle_commit_tick();
    do_reset();
    wr(4'd7, 32'd9);
    bus.commit = 1; bus.frame_tick = 1;
    step();
    bus.commit = 0; bus.frame_tick = 0;
    tests_run++;
    if (bus.cp !== 8'd3 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle commit+tick: cp %0d busy %b expected cp 3 busy 1", bus.cp, bus.busy);
    end
    do_commit();
    bus.wr_valid = 1; bus.wr_addr = 4'd7; bus.wr_data = 32'd5;
    step();
    bus.wr_valid = 0;
    tick();
    act = st;
    tests_run++;
    if (dut_cfg() !== exp_cfg() || bus.cp !== 8'd9 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL frozen staged set: cp %0d busy %b expected cp 9 busy 0", bus.cp, bus.busy);
    end
  endtask

  task automatic test_reset_midway();
    do_reset();
    wr(4'd2, 32'd99);
    do_commit();
    reset = 0;
    step();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.wr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset in pending: busy %b ready %b expected busy 0 ready 1", bus.busy, bus.wr_ready);
    end
    reset = 1;
    model_reset();
    step();
    tick();
    tests_run++;
    if (dut_cfg() !== exp_cfg() || bus.busy !== 1'b0 || bus.p2wid !== 16'd30) begin
      tests_failed++;
      $display("FAIL pending abandoned by reset: cfg %h busy %b expected cfg %h busy 0",
               dut_cfg(), bus.busy, exp_cfg());
    end
  endtask

  task automatic test_random();
    int np, ns;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      for (int a = 0; a < 11; a++) begin
        if (a != 3 && a != 4 && $urandom_range(0, 1) == 1) wr(a[3:0], $urandom);
      end
      wr(4'd14, $urandom);
      np = $urandom_range(1, 4);
      ns = $urandom_range(1, 3);
      run_sweep($urandom_range(0, 65535), $urandom_range(0, 65535), np, ns,
                $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, np * ns * 2 + 2, "random");
    end
  endtask

  initial begin
    bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.commit = 0; bus.frame_tick = 0;
    reset = 0;
    test_reset();
    test_commit_apply();
    test_sweep();
    test_sweep_loop();
    test_saturation();
    test_commit_in_sweep();
    test_idle_commit_tick();
    test_reset_midway();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
